// File: rtl/d_flip_flop.sv
// Rising-edge D register of parameterised width with a synchronous, active-low reset.
// All WIDTH bits load together. Before the first reset edge, out is X in simulation.
module d_flip_flop #(
  parameter int unsigned           WIDTH       = 1,
  parameter logic [WIDTH-1:0]      RESET_VALUE = '0
) (
  output logic [WIDTH-1:0] out,
  input  logic [WIDTH-1:0] d,
  input  logic             clk,
  input  logic             reset
);

  // Reset is sampled only at the edge and takes priority over d.
  always_ff @(posedge clk) begin
    if (!reset) begin
      out <= RESET_VALUE;
    end else begin
      out <= d;
    end
  end

endmodule

// File: tb/tb_d_flip_flop.sv
// Bench for d_flip_flop: directed scenarios followed by randomized traffic, compared against a reference model.
// Two instances are driven from one reset: the default 1-bit form and an 8-bit form with a non-zero reset value.
module tb_d_flip_flop;

  localparam int unsigned W8     = 8;
  localparam logic [W8-1:0] RV8  = 8'hA5;

  logic          clk;
  logic          reset;
  logic          d;
  logic          out;
  logic [W8-1:0] d8;
  logic [W8-1:0] out8;

  logic          exp1;
  logic [W8-1:0] exp8;

  int unsigned n_checks;
  int unsigned n_pass;

  d_flip_flop u_dut (
    .out   (out),
    .d     (d),
    .clk   (clk),
    .reset (reset)
  );

  d_flip_flop #(.WIDTH(W8), .RESET_VALUE(RV8)) u_dut8 (
    .out   (out8),
    .d     (d8),
    .clk   (clk),
    .reset (reset)
  );

  // Clock: 7 ns low, then a 3 ns high pulse. Inputs change on the falling edge, 7 ns ahead of the next rise.
  initial begin
    clk = 1'b0;
    forever begin
      #7 clk = 1'b1;
      #3 clk = 1'b0;
    end
  end

  // Stops a hung run with a reported failure.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d passed=%0d", n_checks, n_pass);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    if (observed === expected) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h, expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Drives one cycle and updates the model: out takes d if reset is high, otherwise the reset value.
  task automatic step(input string tag, input logic rst, input logic dv, input logic [W8-1:0] d8v);
    @(negedge clk);
    reset = rst;
    d     = dv;
    d8    = d8v;
    @(posedge clk);
    #1;
    exp1 = rst ? dv  : 1'b0;
    exp8 = rst ? d8v : RV8;
    check(tag, 32'(out), 32'(exp1));
    check({tag, "_w8"}, 32'(out8), 32'(exp8));
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    reset    = 1'b0;
    d        = 1'b1;
    d8       = '0;
    exp1     = 1'b0;
    exp8     = RV8;

    step("reset", 1'b0, 1'b1, 8'h3C);
    step("set", 1'b1, 1'b1, 8'h5A);
    #89;
    check("set_90ns", 32'(out), 32'(1'b1));
    check("set_90ns_w8", 32'(out8), 32'(8'h5A));
    step("clear_by_data", 1'b1, 1'b0, 8'h00);
    step("set_again", 1'b1, 1'b1, 8'hFF);

    // d toggles inside the low phase; out must not follow.
    @(negedge clk);
    d  = 1'b0;
    d8 = 8'h00;
    #2;
    check("hold_d0", 32'(out), 32'(1'b1));
    check("hold_d0_w8", 32'(out8), 32'(8'hFF));
    d  = 1'b1;
    d8 = 8'hFF;
    #2;
    check("hold_d1", 32'(out), 32'(1'b1));
    @(posedge clk);
    #1;
    check("hold_edge", 32'(out), 32'(1'b1));

    step("reset_priority", 1'b0, 1'b1, 8'hFF);
    step("reset_release", 1'b1, 1'b1, 8'h81);

    // Reset pulses low and returns high before the edge; out must not change.
    @(negedge clk);
    #2 reset = 1'b0;
    #2 reset = 1'b1;
    #1;
    check("sync_reset_mid", 32'(out), 32'(1'b1));
    @(posedge clk);
    #1;
    check("sync_reset_edge", 32'(out), 32'(1'b1));
    check("sync_reset_edge_w8", 32'(out8), 32'(8'h81));

    // Randomized traffic, with reset asserted about one cycle in eight.
    for (int i = 0; i < 200; i++) begin
      step("random", ($urandom_range(7) != 0), 1'($urandom), 8'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
